// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, types and helpers for the 8-point FFT scheduler
package fft_pkg;
  localparam int DATA_W = 32;
  localparam int N = 8;
  localparam int LOG2N = 3;
  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_e;
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction
endpackage

// File: rtl/fft8_bfu_scheduler_if.sv
// fft8_bfu_scheduler_if: sample/bin streams, status and butterfly-unit port bundle
interface fft8_bfu_scheduler_if;
  import fft_pkg::*;
  logic in_valid;
  logic in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic out_valid;
  logic out_ready;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic out_last;
  logic busy;
  logic signed [DATA_W-1:0] bfu_a_real;
  logic signed [DATA_W-1:0] bfu_a_imag;
  logic signed [DATA_W-1:0] bfu_b_real;
  logic signed [DATA_W-1:0] bfu_b_imag;
  logic [1:0] bfu_sel_w;
  logic signed [DATA_W-1:0] bfu_x0_real;
  logic signed [DATA_W-1:0] bfu_x0_imag;
  logic signed [DATA_W-1:0] bfu_x1_real;
  logic signed [DATA_W-1:0] bfu_x1_imag;
  modport master (
    input in_valid, in_real, in_imag, out_ready,
    input bfu_x0_real, bfu_x0_imag, bfu_x1_real, bfu_x1_imag,
    output in_ready, out_valid, out_real, out_imag, out_last, busy,
    output bfu_a_real, bfu_a_imag, bfu_b_real, bfu_b_imag, bfu_sel_w
  );
  modport slave (
    output in_valid, in_real, in_imag, out_ready,
    output bfu_x0_real, bfu_x0_imag, bfu_x1_real, bfu_x1_imag,
    input in_ready, out_valid, out_real, out_imag, out_last, busy,
    input bfu_a_real, bfu_a_imag, bfu_b_real, bfu_b_imag, bfu_sel_w
  );
endinterface

// File: rtl/fft8_addr_gen.sv
// fft8_addr_gen: maps (stage, butterfly) to in-place operand addresses and twiddle index
module fft8_addr_gen
  import fft_pkg::*;
(
  input  logic [1:0]       stage,
  input  logic [1:0]       bfly,
  output logic [LOG2N-1:0] top,
  output logic [LOG2N-1:0] bot,
  output logic [1:0]       sel_w
);
  logic [LOG2N-1:0] half, pos, grp;
  always_comb begin
    half = LOG2N'(1) << stage;
    pos = {1'b0, bfly} & (half - LOG2N'(1));
    grp = {1'b0, bfly} >> stage;
    top = (grp << (stage + 2'd1)) | pos;
    bot = top + half;
    sel_w = 2'(pos << (2'd2 - stage));
  end
endmodule

// File: rtl/fft8_bfu_scheduler.sv
// fft8_bfu_scheduler: loads 8 samples bit-reversed, runs 12 in-place butterflies, streams bins
module fft8_bfu_scheduler
  import fft_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fft8_bfu_scheduler_if.master bus
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  cplx_t mem_q [N];
  cplx_t mem_d [N];
  logic [LOG2N-1:0] top, bot;
  logic [1:0] sel_w;
  logic compute, out_en;
  cplx_t a_op, b_op, bin;
  fft8_addr_gen u_addr (
    .stage(cnt_q[3:2]),
    .bfly (cnt_q[1:0]),
    .top  (top),
    .bot  (bot),
    .sel_w(sel_w)
  );
  assign compute = state_q == COMPUTE;
  assign out_en = state_q == OUT;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    unique case (state_q)
      LOAD: if (bus.in_valid) begin
        mem_d[bitrev3(cnt_q[2:0])] = {bus.in_real, bus.in_imag};
        cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
        state_d = cnt_q == 4'd7 ? COMPUTE : LOAD;
      end
      COMPUTE: begin
        mem_d[top] = {bus.bfu_x0_real, bus.bfu_x0_imag};
        mem_d[bot] = {bus.bfu_x1_real, bus.bfu_x1_imag};
        cnt_d = cnt_q == 4'd11 ? 4'd0 : cnt_q + 4'd1;
        state_d = cnt_q == 4'd11 ? OUT : COMPUTE;
      end
      OUT: if (bus.out_ready) begin
        cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
        state_d = cnt_q == 4'd7 ? LOAD : OUT;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
  assign a_op = compute ? mem_q[top] : '0;
  assign b_op = compute ? mem_q[bot] : '0;
  assign bin = out_en ? mem_q[cnt_q[2:0]] : '0;
  assign {bus.bfu_a_real, bus.bfu_a_imag} = a_op;
  assign {bus.bfu_b_real, bus.bfu_b_imag} = b_op;
  assign bus.bfu_sel_w = compute ? sel_w : 2'd0;
  assign {bus.out_real, bus.out_imag} = bin;
  assign bus.in_ready = state_q == LOAD;
  assign bus.out_valid = out_en;
  assign bus.out_last = out_en && cnt_q == 4'd7;
  assign bus.busy = state_q != LOAD;
endmodule

// File: tb/tb_fft8_bfu_scheduler.sv
// tb_fft8_bfu_scheduler: scoreboard bench with a Q14 butterfly model and directed frames
module tb_fft8_bfu_scheduler;
  import fft_pkg::*;
  typedef struct {
    cplx_t a;
    cplx_t b;
    logic [1:0] w;
  } step_t;
  localparam int REV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  localparam int TOP [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int BOT [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  localparam int SEL [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int bins_seen = 0;
  bit chk_rdy = 1'b0;
  cplx_t exp_q[$];
  step_t sched_q[$];
  cplx_t mon_e;
  step_t mon_s;
  cplx_t bfu_a, bfu_b, bfu_wb;

  fft8_bfu_scheduler_if bus();
  fft8_bfu_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;

  function automatic cplx_t bfu_w(input cplx_t b, input logic [1:0] k);
    longint wr, wi;
    cplx_t r;
    wr = (k == 2'd0) ? 16384 : (k == 2'd2) ? 0 : (k == 2'd1) ? 11585 : -11585;
    wi = (k == 2'd0) ? 0 : (k == 2'd2) ? -16384 : -11585;
    r.re = DATA_W'((wr * b.re - wi * b.im + 8192) >>> 14);
    r.im = DATA_W'((wr * b.im + wi * b.re + 8192) >>> 14);
    return r;
  endfunction

  assign bfu_a = {bus.bfu_a_real, bus.bfu_a_imag};
  assign bfu_b = {bus.bfu_b_real, bus.bfu_b_imag};
  assign bfu_wb = bfu_w(bfu_b, bus.bfu_sel_w);
  assign bus.bfu_x0_real = bfu_a.re + bfu_wb.re;
  assign bus.bfu_x0_imag = bfu_a.im + bfu_wb.im;
  assign bus.bfu_x1_real = bfu_a.re - bfu_wb.re;
  assign bus.bfu_x1_imag = bfu_a.im - bfu_wb.im;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint bfu_or();
    return longint'({bus.bfu_a_real | bus.bfu_a_imag | bus.bfu_b_real | bus.bfu_b_imag, bus.bfu_sel_w});
  endfunction

  always @(negedge clk) begin
    if (chk_rdy) begin
      chk(bus.in_ready == 1'b1, "in_ready_after_last", bus.in_ready, 1);
      chk_rdy = 1'b0;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk(1'b0, "unexpected_bin", bus.out_real, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk(bus.out_real == mon_e.re, $sformatf("bin%0d_real", bins_seen), bus.out_real, mon_e.re);
        chk(bus.out_imag == mon_e.im, $sformatf("bin%0d_imag", bins_seen), bus.out_imag, mon_e.im);
      end
      chk(bus.out_last == (bins_seen == 7), $sformatf("bin%0d_last", bins_seen), bus.out_last, bins_seen == 7);
      if (bus.out_last) chk_rdy = 1'b1;
      bins_seen++;
    end
  end

  always @(negedge clk) begin
    if (bus.busy && !bus.out_valid) begin
      if (sched_q.size() == 0) chk(1'b0, "unexpected_bfly", bus.bfu_sel_w, 0);
      else begin
        mon_s = sched_q.pop_front();
        chk(bus.bfu_sel_w == mon_s.w, "bfly_sel_w", bus.bfu_sel_w, mon_s.w);
        chk(bus.bfu_a_real == mon_s.a.re && bus.bfu_a_imag == mon_s.a.im, "bfly_top_operand", bus.bfu_a_real, mon_s.a.re);
        chk(bus.bfu_b_real == mon_s.b.re && bus.bfu_b_imag == mon_s.b.im, "bfly_bot_operand", bus.bfu_b_real, mon_s.b.re);
      end
    end else chk(bfu_or() == 0, "bfu_idle_zero", bfu_or(), 0);
  end

  task automatic issue(input cplx_t x[8], output cplx_t y[8]);
    cplx_t m[8];
    cplx_t a, wb;
    for (int k = 0; k < 8; k++) m[REV[k]] = x[k];
    for (int i = 0; i < 12; i++) begin
      sched_q.push_back('{a: m[TOP[i]], b: m[BOT[i]], w: 2'(SEL[i])});
      a = m[TOP[i]];
      wb = bfu_w(m[BOT[i]], 2'(SEL[i]));
      m[TOP[i]] = {a.re + wb.re, a.im + wb.im};
      m[BOT[i]] = {a.re - wb.re, a.im - wb.im};
    end
    y = m;
  endtask

  task automatic drive(input cplx_t x[8], input bit timing);
    int n;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      {bus.in_real, bus.in_imag} = x[k];
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk(n < 100, "in_accept_timeout", n, 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = timing;
    bus.in_real = 777;
    bus.in_imag = -777;
    if (timing) begin
      chk(!bus.in_ready, "in_ready_fall", bus.in_ready, 0);
      n = 0;
      while (!bus.out_valid && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk(n == 12, "out_valid_latency", n, 12);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (bins_seen < 8 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(bins_seen == 8, "frame_bins", bins_seen, 8);
    #1;
  endtask

  task automatic frame_hand(input cplx_t x[8], input cplx_t h[8]);
    cplx_t y[8];
    issue(x, y);
    for (int i = 0; i < 8; i++) exp_q.push_back(h[i]);
    bins_seen = 0;
    drive(x, 1'b0);
    wait_done();
  endtask

  task automatic frame_ref(input cplx_t x[8], input bit timing);
    cplx_t y[8];
    issue(x, y);
    for (int i = 0; i < 8; i++) exp_q.push_back(y[i]);
    bins_seen = 0;
    drive(x, timing);
  endtask

  task automatic reset_checks(input string tag);
    chk(bus.in_ready == 1'b1, {tag, "_in_ready"}, bus.in_ready, 1);
    chk(bus.out_valid == 1'b0, {tag, "_out_valid"}, bus.out_valid, 0);
    chk(bus.out_last == 1'b0, {tag, "_out_last"}, bus.out_last, 0);
    chk(bus.busy == 1'b0, {tag, "_busy"}, bus.busy, 0);
    chk(bus.out_real == 0 && bus.out_imag == 0, {tag, "_out_data"}, bus.out_real, 0);
    chk(bfu_or() == 0, {tag, "_bfu_zero"}, bfu_or(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cplx_t x[8], h[8];
    cplx_t held;
    int n;
    bus.in_valid = 1'b0;
    bus.in_real = '0;
    bus.in_imag = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      x[k] = {DATA_W'(k == 0), DATA_W'(0)};
      h[k] = {DATA_W'(1), DATA_W'(0)};
    end
    frame_hand(x, h);
    for (int k = 0; k < 8; k++) begin
      x[k] = {DATA_W'(100), DATA_W'(0)};
      h[k] = {DATA_W'(k == 0 ? 800 : 0), DATA_W'(0)};
    end
    frame_hand(x, h);
    for (int k = 0; k < 8; k++) begin
      x[k] = {DATA_W'(k % 2 == 0 ? 1 : -1), DATA_W'(0)};
      h[k] = {DATA_W'(k == 4 ? 8 : 0), DATA_W'(0)};
    end
    frame_hand(x, h);
    for (int k = 0; k < 8; k++) x[k] = {DATA_W'((k + 1) * 1000), DATA_W'(k * k * 7 - 20)};
    frame_ref(x, 1'b1);
    wait_done();
    for (int k = 0; k < 8; k++) x[k] = {DATA_W'(50 - k * 300), DATA_W'(k * 11 + (k % 3) * 400)};
    frame_ref(x, 1'b0);
    n = 0;
    while (!(bus.out_valid && bins_seen == 3) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n < 60, "reach_bin3", n, 0);
    bus.out_ready = 1'b0;
    held = {bus.out_real, bus.out_imag};
    repeat (5) begin
      @(negedge clk);
      chk(bus.out_real == held.re && bus.out_imag == held.im, "stall_hold", bus.out_real, held.re);
      chk(bus.out_valid && !bus.in_ready && !bus.out_last, "stall_flags", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_done();
    for (int k = 0; k < 8; k++) x[k] = {DATA_W'(k * 5 - 9), DATA_W'(3 - k)};
    frame_ref(x, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_real = 55;
    bus.in_imag = 55;
    @(posedge clk);
    #1;
    reset_checks("mid_reset");
    chk(sched_q.size() == 5, "bflys_before_reset", sched_q.size(), 5);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    sched_q.delete();
    bins_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      x[k] = {DATA_W'(k == 0), DATA_W'(0)};
      h[k] = {DATA_W'(1), DATA_W'(0)};
    end
    frame_hand(x, h);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
